gt_common_ctrl: RTL and testbench

Parametrised reset, lock-supervision and reference-clock-select controller for up to four GTXE2_COMMON QPLLs. It sits between the fabric reset tree and the `gt_common` instances. For each QPLL it sequences QPLLRESET, qualifies QPLLLOCK with a timeout and a stability window, and retries bounded times before declaring failure. It also recovers automatically from lock loss or reference-clock loss, and performs runtime QPLLREFCLKSEL changes with a full relock.

---
 rtl/gt_common_pkg.sv | 39 +++
 rtl/qpll_rst_fsm.sv | 194 +++++++++++++++++++
 rtl/gt_common_ctrl.sv | 73 +++++++
 tb/tb_gt_common_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_common_pkg.sv
// Shared definitions for the GTXE2_COMMON QPLL reset/lock controller.
// Contents: per-QPLL FSM state encoding, QPLLREFCLKSEL encodings, the
// default select value, and a small helper for counter sizing.
package gt_common_pkg;

   // Per-QPLL supervision states.
   typedef enum logic [2:0] {
      ST_PWRUP     = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_READY     = 3'd4,
      ST_HOLD      = 3'd5,
      ST_FAIL      = 3'd6
   } qpll_state_e;

   // QPLLREFCLKSEL encodings of the GTXE2_COMMON primitive.
   localparam logic [2:0] REFCLK_SEL_GTREFCLK0      = 3'b001;
   localparam logic [2:0] REFCLK_SEL_GTREFCLK1      = 3'b010;
   localparam logic [2:0] REFCLK_SEL_GTNORTHREFCLK0 = 3'b011;
   localparam logic [2:0] REFCLK_SEL_GTNORTHREFCLK1 = 3'b100;
   localparam logic [2:0] REFCLK_SEL_GTSOUTHREFCLK0 = 3'b101;
   localparam logic [2:0] REFCLK_SEL_GTSOUTHREFCLK1 = 3'b110;
   localparam logic [2:0] REFCLK_SEL_GTGREFCLK      = 3'b111;

   localparam logic [2:0] DEFAULT_REFCLK_SEL = REFCLK_SEL_GTREFCLK0;

   // Largest of four cycle counts; sizes the shared per-FSM down-counter.
   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/qpll_rst_fsm.sv
// Reset sequencer and lock supervisor for a single QPLL.
// Ports:
//   clk_i, rst_n_i          control clock, async active-low reset
//   qpll_lock_i             QPLLLOCK (asynchronous, synchronised here)
//   qpll_ref_clk_lost_i     QPLLREFCLKLOST (asynchronous, synchronised here)
//   restart_i, sel_req_i    single-cycle relock / refclk-select requests
//   sel_i                   new QPLLREFCLKSEL, sampled with sel_req_i
//   qpll_reset_o            QPLLRESET
//   qpll_ref_clk_sel_o      QPLLREFCLKSEL
//   qpll_ready_o            lock qualified
//   qpll_fail_o             retries exhausted
//   retry_cnt_o             failed attempts in the current sequence
module qpll_rst_fsm #(
   parameter int unsigned PWRUP_WAIT_CYC     = 500,
   parameter int unsigned RESET_CYC          = 64,
   parameter int unsigned LOCK_TIMEOUT_CYC   = 50000,
   parameter int unsigned LOCK_STABLE_CYC    = 1024,
   parameter int unsigned MAX_RETRY          = 3,
   parameter logic [2:0]  DEFAULT_REFCLK_SEL = 3'b001
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       qpll_lock_i,
   input  logic       qpll_ref_clk_lost_i,
   input  logic       restart_i,
   input  logic       sel_req_i,
   input  logic [2:0] sel_i,
   output logic       qpll_reset_o,
   output logic [2:0] qpll_ref_clk_sel_o,
   output logic       qpll_ready_o,
   output logic       qpll_fail_o,
   output logic [1:0] retry_cnt_o
);
   import gt_common_pkg::*;

   localparam int unsigned MAX_CYC = max4(PWRUP_WAIT_CYC, RESET_CYC,
                                          LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
   localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // Counter load values: a state lasting N cycles loads N-1 and exits at 0.
   localparam logic [CNT_W-1:0] LD_PWRUP   = CNT_W'(PWRUP_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] LD_RESET   = CNT_W'(RESET_CYC - 1);
   localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   qpll_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic [2:0]       sel_q, sel_d;
   logic             reset_q, ready_q, fail_q;
   logic             lock_meta_q, lock_sync_q, lost_meta_q, lost_sync_q;
   logic             lost_evt_s, sel_evt_s, restart_evt_s;
   logic [1:0]       retry_inc_s;

   // Two-flop synchronisers for the asynchronous QPLL status inputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         lost_meta_q <= 1'b0;
         lost_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= qpll_lock_i;
         lock_sync_q <= lock_meta_q;
         lost_meta_q <= qpll_ref_clk_lost_i;
         lost_sync_q <= lost_meta_q;
      end
   end

   // Refclk loss is ignored during power-up wait and once failed.
   assign lost_evt_s    = lost_sync_q && (state_q inside {ST_RESET, ST_WAIT_LOCK,
                                                          ST_STABLE, ST_READY, ST_HOLD});
   assign sel_evt_s     = sel_req_i && (state_q inside {ST_READY, ST_FAIL});
   assign restart_evt_s = restart_i && (state_q != ST_PWRUP);
   assign retry_inc_s   = (retry_q == 2'd3) ? 2'd3 : (retry_q + 2'd1);

   // Next-state, counter, retry and select computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : cnt_q;
      retry_d = retry_q;
      sel_d   = sel_q;
      if (lost_evt_s) begin
         state_d = ST_HOLD;
      end else if (sel_evt_s) begin
         state_d = ST_RESET;
         cnt_d   = LD_RESET;
         retry_d = 2'd0;
         sel_d   = sel_i;
      end else if (restart_evt_s) begin
         state_d = ST_RESET;
         cnt_d   = LD_RESET;
         retry_d = 2'd0;
      end else begin
         case (state_q)
            ST_PWRUP: begin
               if (cnt_q == CNT_ZERO) begin
                  state_d = ST_RESET;
                  cnt_d   = LD_RESET;
               end else begin
                  state_d = ST_PWRUP;
               end
            end
            ST_RESET: begin
               if (cnt_q == CNT_ZERO) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = LD_TIMEOUT;
               end else begin
                  state_d = ST_RESET;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_sync_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = LD_STABLE;
               end else if (cnt_q == CNT_ZERO) begin
                  retry_d = retry_inc_s;
                  if (32'(retry_inc_s) >= MAX_RETRY) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d = ST_RESET;
                     cnt_d   = LD_RESET;
                  end
               end else begin
                  state_d = ST_WAIT_LOCK;
               end
            end
            ST_STABLE: begin
               // A dropout restarts qualification but is not a failed attempt.
               if (!lock_sync_q) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = LD_TIMEOUT;
               end else if (cnt_q == CNT_ZERO) begin
                  state_d = ST_READY;
                  retry_d = 2'd0;
               end else begin
                  state_d = ST_STABLE;
               end
            end
            ST_READY: begin
               if (!lock_sync_q) begin
                  state_d = ST_RESET;
                  cnt_d   = LD_RESET;
                  retry_d = 2'd0;
               end else begin
                  state_d = ST_READY;
               end
            end
            ST_HOLD: begin
               // Only reached with refclk restored; loss keeps us above.
               state_d = ST_RESET;
               cnt_d   = LD_RESET;
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_PWRUP;
               cnt_d   = LD_PWRUP;
            end
         endcase
      end
   end

   // State register with outputs registered from the next state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_PWRUP;
         cnt_q   <= LD_PWRUP;
         retry_q <= 2'd0;
         sel_q   <= DEFAULT_REFCLK_SEL;
         reset_q <= 1'b1;
         ready_q <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         sel_q   <= sel_d;
         reset_q <= (state_d == ST_PWRUP) || (state_d == ST_RESET) || (state_d == ST_HOLD);
         ready_q <= (state_d == ST_READY);
         fail_q  <= (state_d == ST_FAIL);
      end
   end

   assign qpll_reset_o       = reset_q;
   assign qpll_ref_clk_sel_o = sel_q;
   assign qpll_ready_o       = ready_q;
   assign qpll_fail_o        = fail_q;
   assign retry_cnt_o        = retry_q;

endmodule

// File: rtl/gt_common_ctrl.sv
// Reset, lock-supervision and refclk-select controller for up to four
// GTXE2_COMMON QPLLs; one independent qpll_rst_fsm per QPLL.
// Ports (per-QPLL vectors are NUM_QPLL wide, packed fields 3 or 2 bits):
//   clk_i, rst_n_i                   control clock / async active-low reset
//   qpll_lock_i, qpll_ref_clk_lost_i QPLL status inputs (asynchronous)
//   restart_i, sel_req_i, sel_i      relock and refclk-select requests
//   qpll_reset_o, qpll_ref_clk_sel_o QPLL control outputs
//   qpll_ready_o, qpll_fail_o        per-QPLL status
//   retry_cnt_o                      per-QPLL failed-attempt count
//   all_ready_o                      every QPLL ready (one cycle behind)
module gt_common_ctrl #(
   parameter int unsigned NUM_QPLL           = 1,
   parameter int unsigned PWRUP_WAIT_CYC     = 500,
   parameter int unsigned RESET_CYC          = 64,
   parameter int unsigned LOCK_TIMEOUT_CYC   = 50000,
   parameter int unsigned LOCK_STABLE_CYC    = 1024,
   parameter int unsigned MAX_RETRY          = 3,
   parameter logic [2:0]  DEFAULT_REFCLK_SEL = gt_common_pkg::DEFAULT_REFCLK_SEL
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NUM_QPLL-1:0]   qpll_lock_i,
   input  logic [NUM_QPLL-1:0]   qpll_ref_clk_lost_i,
   input  logic [NUM_QPLL-1:0]   restart_i,
   input  logic [NUM_QPLL-1:0]   sel_req_i,
   input  logic [3*NUM_QPLL-1:0] sel_i,
   output logic [NUM_QPLL-1:0]   qpll_reset_o,
   output logic [3*NUM_QPLL-1:0] qpll_ref_clk_sel_o,
   output logic [NUM_QPLL-1:0]   qpll_ready_o,
   output logic [NUM_QPLL-1:0]   qpll_fail_o,
   output logic [2*NUM_QPLL-1:0] retry_cnt_o,
   output logic                  all_ready_o
);
   import gt_common_pkg::*;

   logic all_ready_q;

   for (genvar g = 0; g < NUM_QPLL; g++) begin : g_qpll
      qpll_rst_fsm #(
         .PWRUP_WAIT_CYC     (PWRUP_WAIT_CYC),
         .RESET_CYC          (RESET_CYC),
         .LOCK_TIMEOUT_CYC   (LOCK_TIMEOUT_CYC),
         .LOCK_STABLE_CYC    (LOCK_STABLE_CYC),
         .MAX_RETRY          (MAX_RETRY),
         .DEFAULT_REFCLK_SEL (DEFAULT_REFCLK_SEL)
      ) u_fsm (
         .clk_i               (clk_i),
         .rst_n_i             (rst_n_i),
         .qpll_lock_i         (qpll_lock_i[g]),
         .qpll_ref_clk_lost_i (qpll_ref_clk_lost_i[g]),
         .restart_i           (restart_i[g]),
         .sel_req_i           (sel_req_i[g]),
         .sel_i               (sel_i[3*g +: 3]),
         .qpll_reset_o        (qpll_reset_o[g]),
         .qpll_ref_clk_sel_o  (qpll_ref_clk_sel_o[3*g +: 3]),
         .qpll_ready_o        (qpll_ready_o[g]),
         .qpll_fail_o         (qpll_fail_o[g]),
         .retry_cnt_o         (retry_cnt_o[2*g +: 2])
      );
   end

   // Registered aggregate ready.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         all_ready_q <= 1'b0;
      end else begin
         all_ready_q <= &qpll_ready_o;
      end
   end

   assign all_ready_o = all_ready_q;

endmodule

// File: tb/tb_gt_common_ctrl.sv
// Self-checking bench for gt_common_ctrl with two QPLLs and short timings.
// Cycle N is the state seen after the N-th rising edge following reset release.
module tb_gt_common_ctrl;

   localparam int SIG_RST   = 0;
   localparam int SIG_RDY   = 1;
   localparam int SIG_FAIL  = 2;
   localparam int SIG_RETRY = 3;
   localparam int SIG_SEL   = 4;
   localparam int SIG_ALL   = 5;

   typedef struct {
      int         cyc;
      int         sig;
      int         idx;
      logic [7:0] exp;
      string      name;
   } sb_t;

   typedef struct {
      int         cyc;
      logic [1:0] rst;
      logic [1:0] rdy;
      logic       all;
   } vec_t;

   logic       clk_s, rst_n_s;
   logic [1:0] lock_s, lost_s, restart_s, sel_req_s;
   logic [5:0] sel_s;
   logic [1:0] qpll_reset_s, ready_s, fail_s;
   logic [5:0] ref_sel_s;
   logic [3:0] retry_s;
   logic       all_ready_s;

   int  cyc_r;
   int  n_cmp, n_mis;
   sb_t sb_q[$];

   gt_common_ctrl #(
      .NUM_QPLL           (2),
      .PWRUP_WAIT_CYC     (8),
      .RESET_CYC          (4),
      .LOCK_TIMEOUT_CYC   (32),
      .LOCK_STABLE_CYC    (16),
      .MAX_RETRY          (2),
      .DEFAULT_REFCLK_SEL (3'b001)
   ) dut (
      .clk_i               (clk_s),
      .rst_n_i             (rst_n_s),
      .qpll_lock_i         (lock_s),
      .qpll_ref_clk_lost_i (lost_s),
      .restart_i           (restart_s),
      .sel_req_i           (sel_req_s),
      .sel_i               (sel_s),
      .qpll_reset_o        (qpll_reset_s),
      .qpll_ref_clk_sel_o  (ref_sel_s),
      .qpll_ready_o        (ready_s),
      .qpll_fail_o         (fail_s),
      .retry_cnt_o         (retry_s),
      .all_ready_o         (all_ready_s)
   );

   // Free-running 10-unit clock.
   initial begin
      clk_s = 1'b0;
      forever #5 clk_s = ~clk_s;
   end

   // Bench cycle counter, zero while reset is asserted.
   always @(posedge clk_s or negedge rst_n_s) begin
      if (!rst_n_s) cyc_r <= 0;
      else          cyc_r <= cyc_r + 1;
   end

   function automatic logic [7:0] actual(input int sig, input int idx);
      case (sig)
         SIG_RST:   return {7'd0, qpll_reset_s[idx]};
         SIG_RDY:   return {7'd0, ready_s[idx]};
         SIG_FAIL:  return {7'd0, fail_s[idx]};
         SIG_RETRY: return {6'd0, retry_s[2*idx +: 2]};
         SIG_SEL:   return {5'd0, ref_sel_s[3*idx +: 3]};
         SIG_ALL:   return {7'd0, all_ready_s};
         default:   return 8'hee;
      endcase
   endfunction

   task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic push(input int c, input int sig, input int idx, input logic [7:0] e,
                       input string nm);
      sb_t it;
      it.cyc  = c;
      it.sig  = sig;
      it.idx  = idx;
      it.exp  = e;
      it.name = $sformatf("%s[%0d]@%0d", nm, idx, c);
      sb_q.push_back(it);
   endtask

   task automatic sb_check();
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc_r) begin
            compare(sb_q[i].name, actual(sb_q[i].sig, sb_q[i].idx), sb_q[i].exp);
            sb_q.delete(i);
         end
      end
   endtask

   // Check the current cycle at the falling edge, then move past the next rising edge.
   task automatic tick1();
      @(negedge clk_s);
      sb_check();
      @(posedge clk_s);
      #2;
   endtask

   task automatic tick_to(input int t);
      while (cyc_r < t) tick1();
   endtask

   vec_t vec[6];

   initial begin
      n_cmp     = 0;
      n_mis     = 0;
      rst_n_s   = 1'b0;
      lock_s    = 2'b00;
      lost_s    = 2'b00;
      restart_s = 2'b00;
      sel_req_s = 2'b00;
      sel_s     = 6'b001_001;

      // Normal bring-up of both QPLLs, lock raised at cycle 17.
      vec[0] = '{1,  2'b11, 2'b00, 1'b0};
      vec[1] = '{11, 2'b11, 2'b00, 1'b0};
      vec[2] = '{12, 2'b00, 2'b00, 1'b0};
      vec[3] = '{35, 2'b00, 2'b00, 1'b0};
      vec[4] = '{36, 2'b00, 2'b11, 1'b0};
      vec[5] = '{37, 2'b00, 2'b11, 1'b1};

      repeat (3) @(posedge clk_s);
      #2;
      compare("rst reset_o",   {6'd0, qpll_reset_s}, 8'h03);
      compare("rst sel_o",     {2'd0, ref_sel_s},    8'h09);
      compare("rst ready_o",   {6'd0, ready_s},      8'h00);
      compare("rst fail_o",    {6'd0, fail_s},       8'h00);
      compare("rst retry_o",   {4'd0, retry_s},      8'h00);
      compare("rst all_ready", {7'd0, all_ready_s},  8'h00);

      for (int i = 0; i < 6; i++) begin
         for (int q = 0; q < 2; q++) begin
            push(vec[i].cyc, SIG_RST, q, {7'd0, vec[i].rst[q]}, "v_reset");
            push(vec[i].cyc, SIG_RDY, q, {7'd0, vec[i].rdy[q]}, "v_ready");
         end
         push(vec[i].cyc, SIG_ALL, 0, {7'd0, vec[i].all}, "v_all");
      end
      push(37, SIG_RETRY, 0, 8'd0, "v_retry");
      push(37, SIG_RETRY, 1, 8'd0, "v_retry");
      rst_n_s = 1'b1;

      tick_to(17);
      lock_s = 2'b11;

      // Select change on QPLL0 while ready; a second request in WAIT_LOCK is ignored.
      tick_to(40);
      sel_req_s = 2'b01;
      sel_s     = 6'b001_010;
      push(41, SIG_SEL, 0, 8'd2, "sel_new");
      push(41, SIG_RDY, 0, 8'd0, "sel_rdy");
      push(41, SIG_RST, 0, 8'd1, "sel_rst");
      push(41, SIG_SEL, 1, 8'd1, "sel_other");
      push(41, SIG_RDY, 1, 8'd1, "sel_other_rdy");
      push(41, SIG_ALL, 0, 8'd1, "sel_all_lag");
      push(42, SIG_ALL, 0, 8'd0, "sel_all");
      push(44, SIG_RST, 0, 8'd1, "sel_rst");
      push(45, SIG_RST, 0, 8'd0, "sel_rst");
      push(46, SIG_SEL, 0, 8'd2, "sel_ignored");
      push(46, SIG_RST, 0, 8'd0, "sel_ignored_rst");
      push(50, SIG_SEL, 0, 8'd2, "sel_ignored");
      push(61, SIG_RDY, 0, 8'd0, "sel_relock");
      push(62, SIG_RDY, 0, 8'd1, "sel_relock");
      push(63, SIG_ALL, 0, 8'd1, "sel_all");
      tick1();
      sel_req_s = 2'b00;
      tick_to(45);
      sel_req_s = 2'b01;
      sel_s     = 6'b001_011;
      tick1();
      sel_req_s = 2'b00;

      // Restart QPLL0, then a one-cycle lock dropout ten cycles into STABLE.
      tick_to(64);
      restart_s = 2'b01;
      push(64, SIG_RDY, 0, 8'd1, "rs_rdy");
      push(65, SIG_RST, 0, 8'd1, "rs_rst");
      push(65, SIG_RDY, 0, 8'd0, "rs_rdy");
      push(68, SIG_RST, 0, 8'd1, "rs_rst");
      push(69, SIG_RST, 0, 8'd0, "rs_rst");
      push(86, SIG_RDY, 0, 8'd0, "gl_rdy");
      push(90, SIG_RETRY, 0, 8'd0, "gl_retry");
      push(99, SIG_RDY, 0, 8'd0, "gl_rdy");
      push(100, SIG_RDY, 0, 8'd1, "gl_rdy");
      push(100, SIG_RETRY, 0, 8'd0, "gl_retry");
      tick1();
      restart_s = 2'b00;
      tick_to(80);
      lock_s[0] = 1'b0;
      tick1();
      lock_s[0] = 1'b1;

      // Refclk loss on QPLL0 for 20 cycles while ready.
      tick_to(102);
      lost_s[0] = 1'b1;
      push(104, SIG_RDY, 0, 8'd1, "hold_lat");
      for (int c = 105; c <= 128; c++) begin
         push(c, SIG_RST, 0, 8'd1, "hold_rst");
         push(c, SIG_RDY, 0, 8'd0, "hold_rdy");
      end
      push(106, SIG_ALL, 0, 8'd0, "hold_all");
      push(120, SIG_RDY, 1, 8'd1, "hold_other");
      push(129, SIG_RST, 0, 8'd0, "hold_rst");
      push(145, SIG_RDY, 0, 8'd0, "hold_relock");
      push(146, SIG_RDY, 0, 8'd1, "hold_relock");
      tick_to(122);
      lost_s[0] = 1'b0;

      // QPLL1 loses lock from READY and never relocks: one retry, then FAIL.
      tick_to(150);
      lock_s[1] = 1'b0;
      push(152, SIG_RDY, 1, 8'd1, "rf_rdy");
      push(153, SIG_RST, 1, 8'd1, "rf_rst");
      push(153, SIG_RDY, 1, 8'd0, "rf_rdy");
      push(157, SIG_RST, 1, 8'd0, "rf_rst");
      push(188, SIG_RST, 1, 8'd0, "rf_rst");
      push(188, SIG_RETRY, 1, 8'd0, "rf_retry");
      push(189, SIG_RST, 1, 8'd1, "rf_rst");
      push(189, SIG_RETRY, 1, 8'd1, "rf_retry");
      push(192, SIG_RST, 1, 8'd1, "rf_rst");
      push(193, SIG_RST, 1, 8'd0, "rf_rst");
      push(224, SIG_FAIL, 1, 8'd0, "rf_fail");
      push(224, SIG_RETRY, 1, 8'd1, "rf_retry");
      push(225, SIG_FAIL, 1, 8'd1, "rf_fail");
      push(225, SIG_RETRY, 1, 8'd2, "rf_retry");
      push(225, SIG_RST, 1, 8'd0, "rf_rst");
      push(230, SIG_RDY, 0, 8'd1, "ind_rdy0");
      push(230, SIG_ALL, 0, 8'd0, "ind_all");
      push(230, SIG_FAIL, 0, 8'd0, "ind_fail0");

      // Restart out of FAIL, then async reset in the middle of STABLE.
      tick_to(232);
      restart_s = 2'b10;
      lock_s[1] = 1'b1;
      push(233, SIG_FAIL, 1, 8'd0, "fr_fail");
      push(233, SIG_RST, 1, 8'd1, "fr_rst");
      push(233, SIG_RETRY, 1, 8'd0, "fr_retry");
      push(237, SIG_RST, 1, 8'd0, "fr_rst");
      push(244, SIG_RDY, 1, 8'd0, "fr_rdy");
      push(244, SIG_RDY, 0, 8'd1, "fr_rdy0");
      tick1();
      restart_s = 2'b00;
      tick_to(245);

      #1;
      rst_n_s = 1'b0;
      #1;
      compare("arst reset_o",   {6'd0, qpll_reset_s}, 8'h03);
      compare("arst sel_o",     {2'd0, ref_sel_s},    8'h09);
      compare("arst ready_o",   {6'd0, ready_s},      8'h00);
      compare("arst fail_o",    {6'd0, fail_s},       8'h00);
      compare("arst retry_o",   {4'd0, retry_s},      8'h00);
      compare("arst all_ready", {7'd0, all_ready_s},  8'h00);

      while (sb_q.size() > 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s: check never reached", sb_q[0].name);
         void'(sb_q.pop_front());
      end

      repeat (2) @(posedge clk_s);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
